// File: rtl/eth_mac_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_mac_stats_pkg
// Brief    : Event indices and helpers shared by the MAC statistics block.
// Revision : 1.0 - initial release
// ============================================================================
package eth_mac_stats_pkg;

    localparam int NUM_EVENTS = 10;
    localparam int EVT_W      = 4;

    localparam int EVT_TX_UNDERFLOW    = 0;
    localparam int EVT_TX_FIFO_OVF     = 1;
    localparam int EVT_TX_FIFO_BAD     = 2;
    localparam int EVT_TX_FIFO_GOOD    = 3;
    localparam int EVT_RX_BAD_FRAME    = 4;
    localparam int EVT_RX_BAD_FCS      = 5;
    localparam int EVT_RX_FIFO_OVF     = 6;
    localparam int EVT_RX_FIFO_BAD     = 7;
    localparam int EVT_RX_FIFO_GOOD    = 8;
    localparam int EVT_SPEED_CHG       = 9;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_mac_stats_counter.sv
`default_nettype none
// ============================================================================
// Module   : eth_mac_stats_counter
// Brief    : One statistics counter with saturate-or-wrap and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module eth_mac_stats_counter #(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            // an event landing in the clearing cycle belongs to the new interval
            count_d = {{(WIDTH-1){1'b0}}, inc_i};
        end else if (inc_i) begin
            if (&count_q) begin
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = count_q + C_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;

endmodule
`default_nettype wire

// File: rtl/eth_mac_stats_counters.sv
`default_nettype none
// ============================================================================
// Module   : eth_mac_stats_counters
// Brief    : Per-port MAC event counters, atomic shadow snapshot, shadow read port.
//            Define ETH_MAC_STATS_CLR_ON_SNAP_EN to clear live counters on snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module eth_mac_stats_counters
    import eth_mac_stats_pkg::*;
#(
    parameter int  NUM_PORTS     = 4,
    parameter int  COUNTER_WIDTH = 32,
    parameter int  SATURATE      = 1,
    localparam int PORT_AW       = clog2_min1(NUM_PORTS),
    localparam int ADDR_W        = PORT_AW + EVT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS-1:0]     tx_error_underflow_i,
    input  logic [NUM_PORTS-1:0]     tx_fifo_overflow_i,
    input  logic [NUM_PORTS-1:0]     tx_fifo_bad_frame_i,
    input  logic [NUM_PORTS-1:0]     tx_fifo_good_frame_i,
    input  logic [NUM_PORTS-1:0]     rx_error_bad_frame_i,
    input  logic [NUM_PORTS-1:0]     rx_error_bad_fcs_i,
    input  logic [NUM_PORTS-1:0]     rx_fifo_overflow_i,
    input  logic [NUM_PORTS-1:0]     rx_fifo_bad_frame_i,
    input  logic [NUM_PORTS-1:0]     rx_fifo_good_frame_i,
    input  logic [2*NUM_PORTS-1:0]   speed_i,
    input  logic                     snapshot_req_i,
    output logic                     snapshot_done_o,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ADDR_W-1:0]        req_addr_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [COUNTER_WIDTH-1:0] resp_data_o,
    output logic                     resp_err_o
);

    localparam int NUM_CNT = NUM_PORTS * NUM_EVENTS;

    logic [NUM_PORTS-1:0][NUM_EVENTS-1:0]  w_inc;
    logic [NUM_PORTS-1:0]                  w_spd_chg;
    logic [NUM_CNT-1:0][COUNTER_WIDTH-1:0] w_live;
    logic [NUM_CNT-1:0][COUNTER_WIDTH-1:0] shadow_q;
    logic [2*NUM_PORTS-1:0]                speed_prev_q;
    logic [NUM_PORTS-1:0]                  spd_vld_q;
    logic                                  snap_done_q;
    logic                                  w_clr;

    logic [PORT_AW-1:0]       w_port;
    logic [EVT_W-1:0]         w_evt;
    logic                     w_port_bad;
    logic                     w_rd_err;
    logic [COUNTER_WIDTH-1:0] w_rd_data;
    logic                     w_accept;

    logic                     resp_valid_q, resp_valid_d;
    logic [COUNTER_WIDTH-1:0] resp_data_q,  resp_data_d;
    logic                     resp_err_q,   resp_err_d;

`ifdef ETH_MAC_STATS_CLR_ON_SNAP_EN
    assign w_clr = snapshot_req_i;
`else
    assign w_clr = 1'b0;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_spd_chg[p] = spd_vld_q[p] && (speed_i[2*p +: 2] != speed_prev_q[2*p +: 2]);

        assign w_inc[p][EVT_TX_UNDERFLOW] = tx_error_underflow_i[p];
        assign w_inc[p][EVT_TX_FIFO_OVF]  = tx_fifo_overflow_i[p];
        assign w_inc[p][EVT_TX_FIFO_BAD]  = tx_fifo_bad_frame_i[p];
        assign w_inc[p][EVT_TX_FIFO_GOOD] = tx_fifo_good_frame_i[p];
        assign w_inc[p][EVT_RX_BAD_FRAME] = rx_error_bad_frame_i[p];
        assign w_inc[p][EVT_RX_BAD_FCS]   = rx_error_bad_fcs_i[p];
        assign w_inc[p][EVT_RX_FIFO_OVF]  = rx_fifo_overflow_i[p];
        assign w_inc[p][EVT_RX_FIFO_BAD]  = rx_fifo_bad_frame_i[p];
        assign w_inc[p][EVT_RX_FIFO_GOOD] = rx_fifo_good_frame_i[p];
        assign w_inc[p][EVT_SPEED_CHG]    = w_spd_chg[p];

        for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_evt
            eth_mac_stats_counter #(
                .WIDTH    (COUNTER_WIDTH),
                .SATURATE (SATURATE)
            ) u_counter (
                .clk     (clk),
                .rst     (rst),
                .inc_i   (w_inc[p][e]),
                .clr_i   (w_clr),
                .value_o (w_live[p*NUM_EVENTS + e])
            );
        end
    end

    // the first sample after reset only seeds speed_prev_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_prev_q <= '0;
            spd_vld_q    <= '0;
        end else begin
            speed_prev_q <= speed_i;
            spd_vld_q    <= '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            snap_done_q <= 1'b0;
        end else begin
            snap_done_q <= snapshot_req_i;
            if (snapshot_req_i) begin
                shadow_q <= w_live;
            end
        end
    end

    assign w_port = req_addr_i[ADDR_W-1:EVT_W];
    assign w_evt  = req_addr_i[EVT_W-1:0];

    if (NUM_PORTS == (1 << PORT_AW)) begin : g_port_full
        assign w_port_bad = 1'b0;
    end else begin : g_port_part
        assign w_port_bad = (int'(w_port) >= NUM_PORTS);
    end

    assign w_rd_err = w_port_bad || (int'(w_evt) >= NUM_EVENTS);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (!w_rd_err && (i == int'(w_port) * NUM_EVENTS + int'(w_evt))) begin
                w_rd_data = shadow_q[i];
            end
        end
    end

    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (w_accept) begin
            resp_valid_d = 1'b1;
            resp_data_d  = w_rd_data;
            resp_err_d   = w_rd_err;
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign snapshot_done_o = snap_done_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_data_q;
    assign resp_err_o      = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_mac_stats_counters.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_mac_stats_counters
// Brief    : Directed and random checks of eth_mac_stats_counters against a count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_mac_stats_counters;

    localparam int NP = 3;
    localparam int NE = 10;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: 3 ports, 8-bit saturating counters
    logic [8:0][NP-1:0] a_strb;
    logic [2*NP-1:0]    a_speed;
    logic               a_snap, a_done, a_req_valid, a_req_ready;
    logic               a_resp_valid, a_resp_ready, a_resp_err;
    logic [AW-1:0]      a_req_addr;
    logic [7:0]         a_resp_data;

    // instance B: 1 port, 8-bit wrapping counters
    logic [8:0]         b_strb;
    logic [1:0]         b_speed;
    logic               b_snap, b_done, b_req_valid, b_req_ready;
    logic               b_resp_valid, b_resp_ready, b_resp_err;
    logic [4:0]         b_req_addr;
    logic [7:0]         b_resp_data;

    eth_mac_stats_counters #(.NUM_PORTS(NP), .COUNTER_WIDTH(8), .SATURATE(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .tx_error_underflow_i(a_strb[0]), .tx_fifo_overflow_i(a_strb[1]),
        .tx_fifo_bad_frame_i(a_strb[2]),  .tx_fifo_good_frame_i(a_strb[3]),
        .rx_error_bad_frame_i(a_strb[4]), .rx_error_bad_fcs_i(a_strb[5]),
        .rx_fifo_overflow_i(a_strb[6]),   .rx_fifo_bad_frame_i(a_strb[7]),
        .rx_fifo_good_frame_i(a_strb[8]), .speed_i(a_speed),
        .snapshot_req_i(a_snap), .snapshot_done_o(a_done),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
        .resp_data_o(a_resp_data), .resp_err_o(a_resp_err)
    );

    eth_mac_stats_counters #(.NUM_PORTS(1), .COUNTER_WIDTH(8), .SATURATE(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .tx_error_underflow_i(b_strb[0]), .tx_fifo_overflow_i(b_strb[1]),
        .tx_fifo_bad_frame_i(b_strb[2]),  .tx_fifo_good_frame_i(b_strb[3]),
        .rx_error_bad_frame_i(b_strb[4]), .rx_error_bad_fcs_i(b_strb[5]),
        .rx_fifo_overflow_i(b_strb[6]),   .rx_fifo_bad_frame_i(b_strb[7]),
        .rx_fifo_good_frame_i(b_strb[8]), .speed_i(b_speed),
        .snapshot_req_i(b_snap), .snapshot_done_o(b_done),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_data_o(b_resp_data), .resp_err_o(b_resp_err)
    );

    // reference model: unbounded event totals since the last reset/clear
    int unsigned live_m [NP][NE];
    int unsigned sh_m   [NP][NE];
    logic [1:0]  prev_m [NP];
    bit          vld_m  [NP];
    int unsigned b_n, b_sh;

    int total = 0;
    int bad   = 0;

    function automatic int unsigned sat8(input int unsigned n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            for (int e = 0; e < NE; e++) begin
                live_m[p][e] = 0;
                sh_m[p][e]   = 0;
            end
            prev_m[p] = 2'b00;
            vld_m[p]  = 1'b0;
        end
        b_n  = 0;
        b_sh = 0;
    endtask

    // apply the current inputs to the model, then advance one clock
    task automatic tick();
        if (a_snap) begin
            sh_m = live_m;
`ifdef ETH_MAC_STATS_CLR_ON_SNAP_EN
            for (int p = 0; p < NP; p++)
                for (int e = 0; e < NE; e++)
                    live_m[p][e] = 0;
`endif
        end
        for (int p = 0; p < NP; p++) begin
            for (int e = 0; e < 9; e++)
                if (a_strb[e][p]) live_m[p][e]++;
            if (vld_m[p] && (a_speed[2*p +: 2] != prev_m[p])) live_m[p][9]++;
            prev_m[p] = a_speed[2*p +: 2];
            vld_m[p]  = 1'b1;
        end
        if (b_snap) begin
            b_sh = b_n;
`ifdef ETH_MAC_STATS_CLR_ON_SNAP_EN
            b_n = 0;
`endif
        end
        if (b_strb[8]) b_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic a_expect(input logic [AW-1:0] addr, output logic [7:0] d, output logic e);
        int p;
        int ev;
        p  = int'(addr[5:4]);
        ev = int'(addr[3:0]);
        if (p >= NP || ev >= NE) begin
            d = 8'h00;
            e = 1'b1;
        end else begin
            d = 8'(sat8(sh_m[p][ev]));
            e = 1'b0;
        end
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic snap, input string tag);
        logic [7:0] ed;
        logic       ee;
        a_expect(addr, ed, ee);
        chk({tag, " req_ready"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        a_snap      = snap;
        tick();
        a_req_valid = 1'b0;
        a_snap      = 1'b0;
        chk({tag, " resp_valid"}, 32'(a_resp_valid), 32'd1);
        chk({tag, " data"}, 32'(a_resp_data), 32'(ed));
        chk({tag, " err"}, 32'(a_resp_err), 32'(ee));
        if (snap) chk({tag, " snap_done"}, 32'(a_done), 32'd1);
        tick();
        chk({tag, " popped"}, 32'(a_resp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] e1, e2;
        logic       x1, x2;

        a_strb = '0; a_speed = '0; a_snap = 1'b0;
        a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b1;
        b_strb = '0; b_speed = '0; b_snap = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(a_req_ready), 32'd1);
        chk("rst resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst resp_data", 32'(a_resp_data), 32'd0);
        chk("rst snap_done", 32'(a_done), 32'd0);
        rst = 1'b0;

        // read after reset
        rd(6'h00, 1'b0, "t1 rd{0,0}");
        chk("t1 snap_done idle", 32'(a_done), 32'd0);

        // five-cycle strobe then snapshot
        a_strb[8][1] = 1'b1;
        repeat (5) tick();
        a_strb[8][1] = 1'b0;
        a_snap = 1'b1;
        tick();
        a_snap = 1'b0;
        chk("t2 snap_done", 32'(a_done), 32'd1);
        tick();
        chk("t2 snap_done pulse", 32'(a_done), 32'd0);
        rd({2'd1, 4'd8}, 1'b0, "t2 rd{1,8}");
        rd({2'd0, 4'd8}, 1'b0, "t2 rd{0,8}");

        // 300 strobes: saturate on A, wrap on B
        a_strb[0][0] = 1'b1;
        b_strb[8]    = 1'b1;
        repeat (300) tick();
        a_strb[0][0] = 1'b0;
        b_strb[8]    = 1'b0;
        a_snap = 1'b1;
        b_snap = 1'b1;
        tick();
        a_snap = 1'b0;
        b_snap = 1'b0;
        rd({2'd0, 4'd0}, 1'b0, "t3 sat rd{0,0}");
        chk("t3 wrap req_ready", 32'(b_req_ready), 32'd1);
        b_req_valid = 1'b1;
        b_req_addr  = 5'h08;
        tick();
        b_req_valid = 1'b0;
        chk("t3 wrap resp_valid", 32'(b_resp_valid), 32'd1);
        chk("t3 wrap data", 32'(b_resp_data), b_sh % 256);
        chk("t3 wrap err", 32'(b_resp_err), 32'd0);
        tick();

        // reset while a response is pending
        a_resp_ready = 1'b0;
        a_req_valid  = 1'b1;
        a_req_addr   = {2'd1, 4'd8};
        tick();
        a_req_valid = 1'b0;
        chk("t4 pending resp_valid", 32'(a_resp_valid), 32'd1);
        a_speed[5:4] = 2'b10;
        rst = 1'b1;
        #1;
        chk("t4 rst drops resp_valid", 32'(a_resp_valid), 32'd0);
        chk("t4 rst clears resp_data", 32'(a_resp_data), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        a_resp_ready = 1'b1;
        rst = 1'b0;

        // speed sequence on port 2
        tick();
        a_speed[5:4] = 2'b01;
        tick();
        tick();
        a_speed[5:4] = 2'b10;
        tick();
        tick();
        a_snap = 1'b1;
        tick();
        a_snap = 1'b0;
        rd({2'd1, 4'd8}, 1'b0, "t4 shadow cleared rd{1,8}");
        rd({2'd2, 4'd9}, 1'b0, "t4 speed rd{2,9}");
        rd({2'd0, 4'd9}, 1'b0, "t4 speed rd{0,9}");

        // strobe coincident with snapshot, then back-to-back snapshot with a read
        a_strb[3][0] = 1'b1;
        repeat (7) tick();
        a_snap = 1'b1;
        tick();
        a_strb[3][0] = 1'b0;
        a_snap = 1'b0;
        chk("t5 snap_done", 32'(a_done), 32'd1);
        rd({2'd0, 4'd3}, 1'b1, "t5 old snapshot rd{0,3}");
        rd({2'd0, 4'd3}, 1'b0, "t5 live copy rd{0,3}");

        // backpressure: response held while resp_ready is low
        a_expect({2'd0, 4'd3}, e1, x1);
        a_resp_ready = 1'b0;
        a_req_valid  = 1'b1;
        a_req_addr   = {2'd0, 4'd3};
        tick();
        a_req_addr = {2'd2, 4'd9};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6 stall%0d req_ready", i), 32'(a_req_ready), 32'd0);
            chk($sformatf("t6 stall%0d resp_valid", i), 32'(a_resp_valid), 32'd1);
            chk($sformatf("t6 stall%0d data", i), 32'(a_resp_data), 32'(e1));
            tick();
        end
        a_resp_ready = 1'b1;
        #1;
        chk("t6 pop req_ready", 32'(a_req_ready), 32'd1);
        a_expect({2'd2, 4'd9}, e2, x2);
        tick();
        a_req_valid = 1'b0;
        chk("t6 pop+accept resp_valid", 32'(a_resp_valid), 32'd1);
        chk("t6 pop+accept data", 32'(a_resp_data), 32'(e2));
        chk("t6 pop+accept err", 32'(a_resp_err), 32'(x2));
        tick();
        rd({2'd3, 4'd0}, 1'b0, "t6 bad port");
        rd({2'd0, 4'd12}, 1'b0, "t6 bad event");
        rd({2'd1, 4'd15}, 1'b0, "t6 bad event 15");
        rd({2'd2, 4'd9}, 1'b0, "t6 good after bad");

        // random traffic
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 30; c++) begin
                a_strb = 27'($urandom) & 27'($urandom);
                for (int p = 0; p < NP; p++)
                    if ($urandom_range(3) == 0) a_speed[2*p +: 2] = 2'($urandom);
                a_snap = ($urandom_range(7) == 0);
                tick();
            end
            a_strb = '0;
            a_snap = 1'b0;
            for (int k = 0; k < 3; k++)
                rd(6'($urandom), 1'($urandom_range(1)), $sformatf("rnd%0d_%0d", it, k));
        end
        a_snap = 1'b1;
        tick();
        a_snap = 1'b0;
        for (int p = 0; p < NP; p++)
            for (int e = 0; e < NE; e++)
                rd({2'(p), 4'(e)}, 1'b0, $sformatf("final p%0d e%0d", p, e));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
